// File: rtl/multi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multi_pkg
// Brief    : Shared state encoding and default operand width for multi_seq.
// Revision : 1.0  initial release
// ============================================================================
package multi_pkg;

  localparam int MULTI_N_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : multi_pkg
`default_nettype wire

// File: rtl/multi_addshift.sv
`default_nettype none
// ============================================================================
// Module   : multi_addshift
// Brief    : One shift-add multiplication step: conditional add into the upper
//            accumulator half, then a one-bit right shift of {acc_hi, mplier}.
// Revision : 1.0  initial release
// ============================================================================
module multi_addshift #(
  parameter int N = 4
) (
  input  logic [N-1:0] mcand,
  input  logic [N-1:0] acc_hi,
  input  logic [N-1:0] mplier,
  output logic [N-1:0] acc_hi_next,
  output logic [N-1:0] mplier_next
);

  // N+1 bits so the carry of the add survives into the shift
  logic [N:0] sum;

  always_comb begin
    sum         = {1'b0, acc_hi} + (mplier[0] ? {1'b0, mcand} : '0);
    acc_hi_next = sum[N:1];
    mplier_next = {sum[0], mplier[N-1:1]};
  end

endmodule : multi_addshift
`default_nettype wire

// File: rtl/multi_seq.sv
`default_nettype none
// ============================================================================
// Module   : multi_seq
// Brief    : Sequential shift-add multiplier, one multiplier bit per cycle,
//            fixed latency N. Define MULTI_SIGNED_EN for two's complement.
// Revision : 1.0  initial release
// ============================================================================
module multi_seq
  import multi_pkg::*;
#(
  parameter int N  = MULTI_N_DEF,
  parameter int CW = $clog2(N + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] P
);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [N-1:0]    mcand;
  logic [N-1:0]    acc_hi;
  logic [N-1:0]    mplier;
  logic [N-1:0]    acc_hi_next;
  logic [N-1:0]    mplier_next;
  logic [N-1:0]    cap_a;
  logic [N-1:0]    cap_b;
  logic [2*N-1:0]  result;
  logic            capture;

  assign capture = (state != RUN) && start;

  multi_addshift #(.N(N)) u_step (
    .mcand       (mcand),
    .acc_hi      (acc_hi),
    .mplier      (mplier),
    .acc_hi_next (acc_hi_next),
    .mplier_next (mplier_next)
  );

`ifdef MULTI_SIGNED_EN
  // Iterate on magnitudes; the product sign is restored at load time
  logic neg;

  always_comb begin
    cap_a  = A[N-1] ? (~A + 1'b1) : A;
    cap_b  = B[N-1] ? (~B + 1'b1) : B;
    result = neg ? (~{acc_hi_next, mplier_next} + 1'b1)
                 : {acc_hi_next, mplier_next};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      neg <= 1'b0;
    end else if (capture) begin
      neg <= A[N-1] ^ B[N-1];
    end
  end
`else
  always_comb begin
    cap_a  = A;
    cap_b  = B;
    result = {acc_hi_next, mplier_next};
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      P      <= '0;
      cnt    <= '0;
      mcand  <= '0;
      acc_hi <= '0;
      mplier <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (capture) begin
            mcand  <= cap_a;
            mplier <= cap_b;
            acc_hi <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          acc_hi <= acc_hi_next;
          mplier <= mplier_next;
          cnt    <= cnt + 1'b1;
          // Final iteration: the step output already holds the full product
          if (cnt == CW'(N - 1)) begin
            P     <= result;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule : multi_seq
`default_nettype wire

// File: tb/tb_multi_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_seq
// Brief    : Randomized and directed bench for multi_seq against a cycle model
//            derived from the product arithmetic and the N-cycle latency rule.
// Revision : 1.0  initial release
// ============================================================================
module tb_multi_seq;

  localparam int N = 4;

  logic           clk;
  logic           rst;
  logic           start;
  logic [N-1:0]   A;
  logic [N-1:0]   B;
  logic           busy;
  logic           done;
  logic [2*N-1:0] P;

  multi_seq #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .P     (P)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_dones  = 0;

  // Reference model: remaining cycles of the running product, and visible outputs
  int             m_rem  = 0;
  logic [2*N-1:0] m_prod = '0;
  logic [2*N-1:0] m_P    = '0;
  logic           m_done = 1'b0;
  logic           m_busy = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] a, input logic [N-1:0] b);
    longint prod;
`ifdef MULTI_SIGNED_EN
    prod = longint'($signed(a)) * longint'($signed(b));
`else
    prod = longint'(a) * longint'(b);
`endif
    return prod[2*N-1:0];
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_rem = 0; m_P = '0; m_done = 1'b0; m_busy = 1'b0;
    end else if (m_rem > 0) begin
      m_rem--;
      m_done = (m_rem == 0);
      if (m_rem == 0) begin
        m_P    = m_prod;
        m_busy = 1'b0;
      end
    end else begin
      m_done = 1'b0;
      if (start) begin
        m_prod = ref_mul(A, B);
        m_rem  = N;
        m_busy = 1'b1;
      end
    end
  endtask

  task automatic cycle(input logic s, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic r);
    @(negedge clk);
    start = s; A = a; B = b; rst = r;
    @(posedge clk);
    model_edge();
    #1;
    check("busy", {63'd0, busy}, {63'd0, m_busy});
    check("done", {63'd0, done}, {63'd0, m_done});
    check("P", {{(64-2*N){1'b0}}, P}, {{(64-2*N){1'b0}}, m_P});
    if (done) n_dones++;
  endtask

  // Start, then N+1 idle cycles with scrambled operands
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b);
    cycle(1'b1, a, b, 1'b0);
    for (int i = 0; i <= N; i++)
      cycle(1'b0, N'($urandom), N'($urandom), 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; A = '0; B = '0;
    cycle(1'b0, '0, '0, 1'b1);
    cycle(1'b1, 4'd3, 4'd3, 1'b1);
    check("rst_P", {56'd0, P}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);

    // 3x3 with exact busy window and done timing
    cycle(1'b1, 4'd3, 4'd3, 1'b0);
    for (int i = 1; i <= N; i++) begin
      cycle(1'b0, N'($urandom), N'($urandom), 1'b0);
      check("lat_done", {63'd0, done}, {63'd0, (i == N)});
    end
    check("p_3x3", {56'd0, P}, {56'd0, ref_mul(4'd3, 4'd3)});
    cycle(1'b0, '0, '0, 1'b0);
    run_op(4'd7, 4'd1);
    check("p_7x1", {56'd0, P}, {56'd0, ref_mul(4'd7, 4'd1)});
`ifdef MULTI_SIGNED_EN
    run_op(4'hF, 4'd7);  check("p_m1x7",  {56'd0, P}, 64'hF9);
    run_op(4'h8, 4'h8);  check("p_m8xm8", {56'd0, P}, 64'h40);
    run_op(4'h8, 4'd7);  check("p_m8x7",  {56'd0, P}, 64'hC8);
`else
    run_op(4'hA, 4'hA);  check("p_AxA", {56'd0, P}, 64'h64);
    run_op(4'hF, 4'hF);  check("p_FxF", {56'd0, P}, 64'hE1);
    run_op(4'h0, 4'hF);  check("p_0xF", {56'd0, P}, 64'h00);
`endif

    // Start during RUN is ignored
    n_dones = 0;
    cycle(1'b1, 4'd5, 4'd3, 1'b0);
    cycle(1'b1, 4'd2, 4'd2, 1'b0);
    cycle(1'b1, 4'd2, 4'd2, 1'b0);
    for (int i = 0; i < N; i++) cycle(1'b0, 4'd2, 4'd2, 1'b0);
    check("ign_P", {56'd0, P}, 64'h0F);
    check("ign_dones", 64'(n_dones), 64'd1);

    // Reset during RUN abandons the product
    n_dones = 0;
    cycle(1'b1, 4'd6, 4'd6, 1'b0);
    cycle(1'b0, 4'd6, 4'd6, 1'b0);
    cycle(1'b0, 4'd6, 4'd6, 1'b0);
    cycle(1'b0, 4'd6, 4'd6, 1'b1);
    for (int i = 0; i < N; i++) cycle(1'b0, '0, '0, 1'b0);
    check("abort_dones", 64'(n_dones), 64'd0);
    check("abort_P", {56'd0, P}, 64'd0);
    run_op(4'd2, 4'd3);
    check("p_2x3", {56'd0, P}, 64'h06);

    // Back-to-back with start held high
    n_dones = 0;
    for (int i = 0; i < 3 * (N + 1); i++) cycle(1'b1, 4'd2, 4'd5, 1'b0);
    check("b2b_dones", 64'(n_dones), 64'd3);
    check("b2b_P", {56'd0, P}, 64'h0A);
    cycle(1'b0, '0, '0, 1'b1);

    // Random traffic with occasional reset
    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(0, 3) != 0), N'($urandom), N'($urandom),
            ($urandom_range(0, 40) == 0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_multi_seq
`default_nettype wire
